// File: rtl/clock_pkg.sv
// Shared constants and helpers for the BCD time-of-day counter.
// Time is packed BCD HH[31:24] MM[23:16] SS[15:8] CC[7:0], 24 h internally.
package clock_pkg;

   localparam int HH_LSB = 24;
   localparam int MM_LSB = 16;
   localparam int SS_LSB = 8;
   localparam int CC_LSB = 0;

   localparam logic [7:0] HH_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;
   localparam logic [7:0] CC_MAX = 8'h99;

   localparam int PRESCALE = 10;
   localparam logic [3:0] PRE_LAST = 4'(PRESCALE - 1);

   // True when every nibble is a decimal digit and each field is within its range.
   function automatic logic bcd_time_valid(input logic [31:0] t);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (t[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      if (t[HH_LSB +: 8] > HH_MAX) ok = 1'b0;
      if (t[MM_LSB +: 8] > MS_MAX) ok = 1'b0;
      if (t[SS_LSB +: 8] > MS_MAX) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] hh_to_12h(input logic [7:0] hh);
      logic [7:0] r;
      case (hh)
         8'h00:   r = 8'h12;
         8'h13:   r = 8'h01;
         8'h14:   r = 8'h02;
         8'h15:   r = 8'h03;
         8'h16:   r = 8'h04;
         8'h17:   r = 8'h05;
         8'h18:   r = 8'h06;
         8'h19:   r = 8'h07;
         8'h20:   r = 8'h08;
         8'h21:   r = 8'h09;
         8'h22:   r = 8'h10;
         8'h23:   r = 8'h11;
         default: r = hh;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/time_counter_if.sv
// Control/status bundle of the time counter: load, run, display and pulse outputs.
interface time_counter_if;
   logic        PE;
   logic [31:0] set_time;
   logic        run;
   logic        time_mode;
   logic [31:0] alarm_time;
   logic [31:0] show_time;
   logic        pm;
   logic        tick_1s;
   logic        alarm_hit;
   logic        load_err;

   modport master (
      output PE, set_time, run, time_mode, alarm_time,
      input  show_time, pm, tick_1s, alarm_hit, load_err
   );

   modport slave (
      input  PE, set_time, run, time_mode, alarm_time,
      output show_time, pm, tick_1s, alarm_hit, load_err
   );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX, with synchronous load and carry-out.
// next_value exposes the value the register takes at the coming edge.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = CC_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic [7:0] value,
   output logic [7:0] next_value,
   output logic       carry
);

   // Next-state: load wins over increment; wrap to 00 past MAX.
   always_comb begin
      next_value = value;
      carry      = en && (value == MAX);
      if (load) begin
         next_value = load_val;
      end else if (en) begin
         next_value = (value == MAX) ? 8'h00 : bcd_inc(value);
      end else begin
         next_value = value;
      end
   end

   // Digit register.
   always_ff @(posedge clk) begin
      if (rst) value <= 8'h00;
      else     value <= next_value;
   end

endmodule

// File: rtl/time_counter.sv
// 24 h BCD time-of-day counter (hundredths resolution) clocked at 1 kHz,
// with validated parallel load, alarm compare and 12/24 h presentation.
module time_counter
   import clock_pkg::*;
(
   input  logic           CP_1KHz,
   input  logic           CR,
   time_counter_if.slave  tc
);

   logic [3:0]  pre_r;
   logic        load_ok_s;
   logic        cc_en_s;
   logic [7:0]  hh_s, mm_s, ss_s, cc_s;
   logic [7:0]  hh_next_s, mm_next_s, ss_next_s, cc_next_s;
   logic        cc_carry_s, ss_carry_s, mm_carry_s;
   logic        day_wrap_unused_s;
   logic [31:0] next_unused_s;
   logic        tick_1s_r, alarm_hit_r, load_err_r;

   assign load_ok_s = tc.PE && bcd_time_valid(tc.set_time);
   assign cc_en_s   = tc.run && !load_ok_s && (pre_r == PRE_LAST);

   // Divide-by-ten prescaler; restarted by a load, frozen while run is low.
   always_ff @(posedge CP_1KHz) begin
      if (CR)                     pre_r <= 4'd0;
      else if (load_ok_s)         pre_r <= 4'd0;
      else if (!tc.run)           pre_r <= pre_r;
      else if (pre_r == PRE_LAST) pre_r <= 4'd0;
      else                        pre_r <= pre_r + 4'd1;
   end

   bcd_mod_counter #(.MAX(CC_MAX)) u_cc (
      .clk(CP_1KHz), .rst(CR), .load(load_ok_s), .load_val(tc.set_time[CC_LSB +: 8]),
      .en(cc_en_s), .value(cc_s), .next_value(cc_next_s), .carry(cc_carry_s)
   );

   bcd_mod_counter #(.MAX(MS_MAX)) u_ss (
      .clk(CP_1KHz), .rst(CR), .load(load_ok_s), .load_val(tc.set_time[SS_LSB +: 8]),
      .en(cc_carry_s), .value(ss_s), .next_value(ss_next_s), .carry(ss_carry_s)
   );

   bcd_mod_counter #(.MAX(MS_MAX)) u_mm (
      .clk(CP_1KHz), .rst(CR), .load(load_ok_s), .load_val(tc.set_time[MM_LSB +: 8]),
      .en(ss_carry_s), .value(mm_s), .next_value(mm_next_s), .carry(mm_carry_s)
   );

   bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
      .clk(CP_1KHz), .rst(CR), .load(load_ok_s), .load_val(tc.set_time[HH_LSB +: 8]),
      .en(mm_carry_s), .value(hh_s), .next_value(hh_next_s), .carry(day_wrap_unused_s)
   );

   assign next_unused_s = {tc.alarm_time[15:0], ss_next_s, cc_next_s};

   // Event pulses. An SS rollover means the new time ends in :00.00, so only
   // the next HH:MM needs comparing against the alarm.
   always_ff @(posedge CP_1KHz) begin
      if (CR) begin
         tick_1s_r   <= 1'b0;
         alarm_hit_r <= 1'b0;
         load_err_r  <= 1'b0;
      end else begin
         tick_1s_r   <= cc_carry_s;
         alarm_hit_r <= ss_carry_s && ({hh_next_s, mm_next_s} == tc.alarm_time[31:16]);
         load_err_r  <= tc.PE && !load_ok_s;
      end
   end

   assign tc.show_time = {(tc.time_mode ? hh_to_12h(hh_s) : hh_s), mm_s, ss_s, cc_s};
   assign tc.pm        = (hh_s >= 8'h12);
   assign tc.tick_1s   = tick_1s_r;
   assign tc.alarm_hit = alarm_hit_r;
   assign tc.load_err  = load_err_r;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: directed table, corner sequences and
// random traffic against a centisecond-of-day reference model.
module tb_time_counter;

   logic clk = 1'b0;
   logic cr;
   time_counter_if tc();

   time_counter dut (.CP_1KHz(clk), .CR(cr), .tc(tc));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: time as centiseconds since midnight plus prescaler phase.
   int   m_t = 0;
   int   m_pre = 0;
   logic m_tick = 1'b0, m_alarm = 1'b0, m_err = 1'b0;

   typedef struct {
      logic        cr;
      logic        pe;
      logic [31:0] st;
      logic        mode;
      logic [31:0] show;
      logic        pm;
      logic        err;
   } vec_t;

   vec_t tbl[16];

   function automatic int dig(input logic [31:0] v, input int i);
      return int'(v[4*i +: 4]);
   endfunction

   function automatic bit time_ok(input logic [31:0] v);
      for (int i = 0; i < 8; i++) if (dig(v, i) > 9) return 1'b0;
      return (dig(v,7)*10 + dig(v,6) < 24) && (dig(v,5)*10 + dig(v,4) < 60) &&
             (dig(v,3)*10 + dig(v,2) < 60);
   endfunction

   function automatic int to_cs(input logic [31:0] v);
      int hh, mm, ss, cc;
      hh = dig(v,7)*10 + dig(v,6);
      mm = dig(v,5)*10 + dig(v,4);
      ss = dig(v,3)*10 + dig(v,2);
      cc = dig(v,1)*10 + dig(v,0);
      return ((hh*60 + mm)*60 + ss)*100 + cc;
   endfunction

   function automatic logic [7:0] bcd8(input int x);
      return 8'((x/10)*16 + x%10);
   endfunction

   function automatic logic [31:0] show_of(input int t, input logic mode);
      int hh, dh;
      hh = t / 360000;
      dh = hh;
      if (mode) dh = (hh == 0) ? 12 : ((hh > 12) ? hh - 12 : hh);
      return {bcd8(dh), bcd8((t/6000) % 60), bcd8((t/100) % 60), bcd8(t % 100)};
   endfunction

   task automatic model_edge();
      m_tick = 1'b0; m_alarm = 1'b0; m_err = 1'b0;
      if (cr) begin
         m_t = 0; m_pre = 0;
      end else if (tc.PE && time_ok(tc.set_time)) begin
         m_t = to_cs(tc.set_time); m_pre = 0;
      end else begin
         m_err = tc.PE;
         if (tc.run) begin
            if (m_pre == 9) begin
               m_pre = 0;
               m_t = (m_t + 1) % 8640000;
               m_tick = (m_t % 100 == 0);
               m_alarm = (m_t % 6000 == 0) &&
                  ({bcd8(m_t/360000), bcd8((m_t/6000) % 60)} == tc.alarm_time[31:16]);
            end else begin
               m_pre = m_pre + 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      apply();
      check("show_time", tc.show_time, show_of(m_t, tc.time_mode));
      check("pm", {31'd0, tc.pm}, {31'd0, (m_t >= 4320000)});
      check("tick_1s", {31'd0, tc.tick_1s}, {31'd0, m_tick});
      check("alarm_hit", {31'd0, tc.alarm_hit}, {31'd0, m_alarm});
      check("load_err", {31'd0, tc.load_err}, {31'd0, m_err});
   endtask

   initial begin
      int ticks, hits, hh, mm, ss, cc, nm;
      bit found;

      cr = 1'b1;
      tc.PE = 1'b0; tc.set_time = 32'h0; tc.run = 1'b0;
      tc.time_mode = 1'b0; tc.alarm_time = 32'h0;

      // Directed single-edge vectors, run held low.
      tbl[0]  = '{1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 32'h12000000, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 32'h00150000, 1'b1, 32'h12150000, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 32'h13150000, 1'b1, 32'h01150000, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h13150000, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 32'h24000000, 1'b0, 32'h13150000, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 32'h24000000, 1'b0, 32'h13150000, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'h1036000A, 1'b0, 32'h13150000, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 32'h10360000, 1'b0, 32'h10360000, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 32'h10360300, 1'b0, 32'h10360300, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 32'h11111111, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 32'h23595999, 1'b1, 32'h11595999, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 32'h105A0000, 1'b1, 32'h11595999, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 32'h12000000, 1'b1, 32'h12000000, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 32'h12000000, 1'b0, 1'b0};

      for (int i = 0; i < 16; i++) begin
         cr = tbl[i].cr; tc.PE = tbl[i].pe; tc.set_time = tbl[i].st;
         tc.time_mode = tbl[i].mode;
         apply();
         check($sformatf("tbl%0d_show", i), tc.show_time, tbl[i].show);
         check($sformatf("tbl%0d_pm", i), {31'd0, tc.pm}, {31'd0, tbl[i].pm});
         check($sformatf("tbl%0d_err", i), {31'd0, tc.load_err}, {31'd0, tbl[i].err});
         check($sformatf("tbl%0d_tick", i), {31'd0, tc.tick_1s}, 32'd0);
         check($sformatf("tbl%0d_alarm", i), {31'd0, tc.alarm_hit}, 32'd0);
      end

      // Count from reset: 10 cycles -> one hundredth, 1000 cycles -> one second.
      cr = 1'b1; tc.PE = 1'b0; tc.time_mode = 1'b0; tc.run = 1'b0;
      step();
      check("reset_show", tc.show_time, 32'h00000000);
      cr = 1'b0; tc.run = 1'b1;
      ticks = 0;
      repeat (10) begin step(); if (tc.tick_1s) ticks++; end
      check("show_after_10", tc.show_time, 32'h00000001);
      repeat (990) begin step(); if (tc.tick_1s) ticks++; end
      check("show_after_1000", tc.show_time, 32'h00000100);
      check("tick_count", ticks, 32'd1);

      // Midnight roll-over.
      tc.PE = 1'b1; tc.set_time = 32'h23595999;
      step();
      check("roll_pm_before", {31'd0, tc.pm}, 32'd1);
      tc.PE = 1'b0;
      repeat (9) step();
      check("roll_held", tc.show_time, 32'h23595999);
      step();
      check("roll_show", tc.show_time, 32'h00000000);
      check("roll_pm_after", {31'd0, tc.pm}, 32'd0);
      check("roll_tick", {31'd0, tc.tick_1s}, 32'd1);

      // Back-to-back loads, prescaler restarts after the second.
      tc.PE = 1'b1; tc.set_time = 32'h10360000;
      step();
      check("load1", tc.show_time, 32'h10360000);
      tc.set_time = 32'h10360300;
      step();
      check("load2", tc.show_time, 32'h10360300);
      tc.PE = 1'b0;
      repeat (9) step();
      check("presc_9", tc.show_time, 32'h10360300);
      step();
      check("presc_10", tc.show_time, 32'h10360301);

      // Rejected loads leave the count running.
      tc.PE = 1'b1; tc.set_time = 32'h00000000;
      step();
      tc.PE = 1'b0;
      repeat (5) step();
      tc.PE = 1'b1; tc.set_time = 32'h24000000;
      step();
      check("bad_hh_err", {31'd0, tc.load_err}, 32'd1);
      tc.PE = 1'b0;
      step();
      check("err_clear", {31'd0, tc.load_err}, 32'd0);
      step();
      tc.PE = 1'b1; tc.set_time = 32'h105A0000;
      step();
      check("bad_mm_err", {31'd0, tc.load_err}, 32'd1);
      tc.PE = 1'b0;
      step();
      check("uninterrupted", tc.show_time, 32'h00000001);

      // Alarm on reaching 10:37, none on a load of 10:37.
      tc.alarm_time = 32'h10370000;
      tc.PE = 1'b1; tc.set_time = 32'h10365999;
      step();
      tc.PE = 1'b0;
      found = 1'b0; hits = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (tc.show_time == 32'h10370000) begin
            found = 1'b1;
            check("alarm_at_match", {31'd0, tc.alarm_hit}, 32'd1);
         end else if (tc.alarm_hit) begin
            hits++;
         end
      end
      check("alarm_reached", {31'd0, found}, 32'd1);
      check("alarm_early", hits, 32'd0);
      step();
      check("alarm_one_cycle", {31'd0, tc.alarm_hit}, 32'd0);
      tc.PE = 1'b1; tc.set_time = 32'h10370000;
      step();
      check("alarm_on_load", {31'd0, tc.alarm_hit}, 32'd0);
      tc.PE = 1'b0;

      // Random traffic with loads placed just before minute boundaries.
      for (int c = 0; c < 4000; c++) begin
         cr = ($urandom_range(0, 499) == 0);
         tc.run = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 63) == 0) tc.time_mode = ~tc.time_mode;
         tc.PE = ($urandom_range(0, 249) == 0);
         if (tc.PE) begin
            if ($urandom_range(0, 3) == 0) begin
               tc.set_time = $urandom();
            end else begin
               hh = $urandom_range(0, 23);
               mm = $urandom_range(0, 59);
               ss = ($urandom_range(0, 1) == 1) ? 59 : $urandom_range(0, 59);
               cc = $urandom_range(80, 99);
               tc.set_time = {bcd8(hh), bcd8(mm), bcd8(ss), bcd8(cc)};
               nm = (hh*60 + mm + 1) % 1440;
               if ($urandom_range(0, 1) == 1)
                  tc.alarm_time = {bcd8(nm/60), bcd8(nm%60), 16'h0000};
            end
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
